// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: multdiv FSM states,
// default watchdog sizing, the nop control word and a saturating counter helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    localparam int MD_TIMEOUT_DEF = 40;
    localparam int CNT_W_DEF      = 6;

    // Control word a flushed latch loads; rd=0 so it can never create a hazard.
    localparam logic [13:0] NOP_CTRL = 14'b0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare: a lw in DX whose destination feeds a source the FD instruction
// actually reads. $0 is never a real dependency.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rs,
    input  logic       fd_uses_rt,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    output logic       load_use
);

    logic rs_hit, rt_hit;

    assign rs_hit   = fd_uses_rs && (fd_rs == dx_rd);
    assign rt_hit   = fd_uses_rt && (fd_rt == dx_rd);
    assign load_use = dx_is_load && (dx_rd != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: branch flush, multdiv
// hold with watchdog, load-use bubble, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic [4:0]  dx_rd,
    input  logic        dx_is_load,
    input  logic        dx_is_mult,
    input  logic        dx_is_div,
    input  logic        xm_branch_taken,
    input  logic        md_ready,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        dx_wren,
    output logic        xm_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic        md_result_sel,
    output logic        md_busy,
    output logic        md_error,
    output logic [31:0] stall_cycles
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] wd, wd_nxt;
    logic             load_use;
    logic             md_expired;

    hazard_detect u_hazard_detect (
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rs (fd_uses_rs),
        .fd_uses_rt (fd_uses_rt),
        .dx_rd      (dx_rd),
        .dx_is_load (dx_is_load),
        .load_use   (load_use)
    );

    assign md_expired = (wd == CNT_W'(MD_TIMEOUT - 1));
    assign md_busy    = (state != MD_IDLE);
    assign mw_wren    = 1'b1;
    assign xm_wren    = 1'b1;

    // Reset forces the pass-through pattern so latches keep loading while held.
    always_comb begin
        pc_wren       = 1'b1;
        fd_wren       = 1'b1;
        dx_wren       = 1'b1;
        fd_flush      = 1'b0;
        dx_flush      = 1'b0;
        xm_flush      = 1'b0;
        md_start_mult = 1'b0;
        md_start_div  = 1'b0;
        md_result_sel = 1'b0;
        md_error      = 1'b0;
        state_nxt     = state;
        wd_nxt        = wd;
        if (!reset) begin
            case (state)
                MD_IDLE: begin
                    if (xm_branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (dx_is_mult || dx_is_div) begin
                        md_start_mult = dx_is_mult;
                        md_start_div  = !dx_is_mult;
                        pc_wren       = 1'b0;
                        fd_wren       = 1'b0;
                        dx_wren       = 1'b0;
                        xm_flush      = 1'b1;
                        wd_nxt        = '0;
                        state_nxt     = MD_WAIT;
                    end else if (load_use) begin
                        pc_wren  = 1'b0;
                        fd_wren  = 1'b0;
                        dx_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    // XM only holds bubbles here, so no branch can arrive.
                    if (md_ready || md_expired) begin
                        md_result_sel = 1'b1;
                        md_error      = !md_ready;
                        state_nxt     = MD_IDLE;
                    end else begin
                        pc_wren  = 1'b0;
                        fd_wren  = 1'b0;
                        dx_wren  = 1'b0;
                        xm_flush = 1'b1;
                        wd_nxt   = wd + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= MD_IDLE;
            wd           <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            if (!pc_wren)
                stall_cycles <= sat_inc32(stall_cycles);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the hazard/multdiv rules.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  fd_rs = '0, fd_rt = '0, dx_rd = '0;
    logic        fd_uses_rs = 0, fd_uses_rt = 0, dx_is_load = 0;
    logic        dx_is_mult = 0, dx_is_div = 0, xm_branch_taken = 0, md_ready = 0;
    logic        pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
    logic        fd_flush, dx_flush, xm_flush;
    logic        md_start_mult, md_start_div, md_result_sel, md_busy, md_error;
    logic [31:0] stall_cycles;

    int     n_checks = 0;
    int     n_errs   = 0;
    bit     m_busy   = 0;
    int     m_waited = 0;
    longint m_stall  = 0;

    localparam logic [12:0] PASS_VEC = 13'b11111_000_00_0_0_0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
        .xm_branch_taken(xm_branch_taken), .md_ready(md_ready),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .dx_wren(dx_wren), .xm_wren(xm_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start_mult(md_start_mult), .md_start_div(md_start_div), .md_result_sel(md_result_sel),
        .md_busy(md_busy), .md_error(md_error), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren, fd_flush, dx_flush, xm_flush,
                md_start_mult, md_start_div, md_result_sel, md_busy, md_error};
    endfunction

    // Expected outputs from the hazard rules, in priority order.
    function automatic logic [12:0] model_outs();
        bit pc = 1, fd = 1, dx = 1, fdf = 0, dxf = 0, xmf = 0, sm = 0, sd = 0, sel = 0, err = 0;
        bit hz;
        if (reset) return PASS_VEC;
        hz = dx_is_load && dx_rd != 0 &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        if (m_busy) begin
            if (md_ready || m_waited == TO - 1) begin
                sel = 1;
                err = !md_ready;
            end else begin
                pc = 0; fd = 0; dx = 0; xmf = 1;
            end
        end else if (xm_branch_taken) begin
            fdf = 1; dxf = 1;
        end else if (dx_is_mult || dx_is_div) begin
            sm = dx_is_mult; sd = !dx_is_mult;
            pc = 0; fd = 0; dx = 0; xmf = 1;
        end else if (hz) begin
            pc = 0; fd = 0; dxf = 1;
        end
        return {pc, fd, dx, 1'b1, 1'b1, fdf, dxf, xmf, sm, sd, sel, m_busy, err};
    endfunction

    // One cycle: check at negedge, advance the model at posedge, return #1 after it.
    task automatic step(output logic [12:0] got);
        logic [12:0] e;
        bit rel;
        @(negedge clock);
        e   = model_outs();
        got = obs_vec();
        chk("outs", 32'(got), 32'(e));
        chk("stall_cycles", stall_cycles, reset ? 32'd0 : 32'(m_stall));
        rel = md_ready || m_waited == TO - 1;
        @(posedge clock);
        if (reset) begin
            m_busy = 0; m_waited = 0; m_stall = 0;
        end else begin
            if (!e[12] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_busy) begin
                if (rel) m_busy = 0;
                else m_waited++;
            end else if (!xm_branch_taken && (dx_is_mult || dx_is_div)) begin
                m_busy = 1; m_waited = 0;
            end
        end
        #1;
    endtask

    task automatic quiet();
        fd_rs = 0; fd_rt = 0; dx_rd = 0; fd_uses_rs = 0; fd_uses_rt = 0;
        dx_is_load = 0; dx_is_mult = 0; dx_is_div = 0; xm_branch_taken = 0; md_ready = 0;
    endtask

    initial begin
        logic [12:0] g;
        logic [31:0] s0;
        int cnt_a, cnt_b;

        // Reset state
        step(g);
        step(g);
        reset = 0;
        step(g);

        // Load-use: lw $5 in DX, add $6,$5,$7 in FD -> one bubble
        s0 = stall_cycles;
        dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_rt = 7; fd_uses_rs = 1; fd_uses_rt = 1;
        step(g);
        chk("lu_bubble", 32'({g[12], g[11], g[6]}), 32'b001);
        quiet();
        step(g);
        chk("lu_stall_delta", stall_cycles - s0, 32'd1);

        // Same hazard shape but dx_rd=0, then fd_uses_rs=0 -> no stall
        s0 = stall_cycles;
        dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_uses_rs = 1;
        step(g);
        dx_rd = 5; fd_rs = 5; fd_uses_rs = 0; fd_rt = 7;
        step(g);
        chk("lu_none_delta", stall_cycles - s0, 32'd0);
        quiet();

        // mul, ready after 5 WAIT cycles
        s0 = stall_cycles; cnt_a = 0; cnt_b = 0;
        dx_is_mult = 1;
        for (int i = 0; i < 7; i++) begin
            md_ready = (i == 6);
            step(g);
            cnt_a += int'(g[4]);
            cnt_b += int'(g[2]);
        end
        quiet();
        step(g);
        chk("mul_stalls", stall_cycles - s0, 32'd6);
        chk("mul_starts", 32'(cnt_a), 32'd1);
        chk("mul_sel", 32'(cnt_b), 32'd1);
        chk("mul_idle", 32'(md_busy), 32'd0);

        // div, ready never -> watchdog release with one md_error pulse
        s0 = stall_cycles; cnt_a = 0; cnt_b = 0;
        dx_is_div = 1;
        for (int i = 0; i < TO + 1; i++) begin
            step(g);
            cnt_a += int'(g[0]);
            cnt_b += int'(g[3]);
        end
        quiet();
        step(g);
        chk("div_err_pulses", 32'(cnt_a), 32'd1);
        chk("div_starts", 32'(cnt_b), 32'd1);
        chk("div_stalls", stall_cycles - s0, 32'(TO));

        // Branch beats multdiv and load-use in the same cycle
        s0 = stall_cycles;
        xm_branch_taken = 1; dx_is_mult = 1; dx_is_load = 1; dx_rd = 3; fd_rs = 3; fd_uses_rs = 1;
        step(g);
        chk("br_flush", 32'({g[7], g[6], g[4], g[12]}), 32'b1101);
        quiet();
        step(g);
        chk("br_stall_delta", stall_cycles - s0, 32'd0);

        // Async reset in the middle of MD_WAIT
        dx_is_mult = 1;
        for (int i = 0; i < 3; i++) step(g);
        #2 reset = 1;
        #1;
        chk("rst_async_outs", 32'(obs_vec()), 32'(PASS_VEC));
        chk("rst_async_stall", stall_cycles, 32'd0);
        step(g);
        reset = 0;
        dx_is_mult = 0;
        step(g);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            fd_rs      = 5'($urandom_range(0, 3));
            fd_rt      = 5'($urandom_range(0, 3));
            dx_rd      = 5'($urandom_range(0, 3));
            fd_uses_rs = 1'($urandom_range(0, 1));
            fd_uses_rt = 1'($urandom_range(0, 1));
            dx_is_load = ($urandom_range(0, 2) == 0);
            dx_is_mult = ($urandom_range(0, 9) == 0);
            dx_is_div  = ($urandom_range(0, 9) == 0);
            md_ready   = ($urandom_range(0, 9) == 0);
            xm_branch_taken = !m_busy && ($urandom_range(0, 7) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            step(g);
        end
        reset = 0;
        quiet();
        step(g);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
